fp_add_sequencer: RTL and testbench
===================================

# fp_add_sequencer

Test-vector sequencer that sits directly upstream of the FP32 adder. It fetches operand A, operand B and the expected sum for each vector from word memory. It hands A and B to the adder over a valid/ready handshake, captures the sum, compares it bit-exactly against the expected word, and writes the sum back to memory. Pass/fail counts and a per-vector match flag are exported for the testbench and the board.

## Interface
Parameters:
- `ADDR_W`, 8: memory word-address width. Vector i occupies words 4i..4i+3.
- `TIMEOUT`, 64: maximum cycles to wait for an adder result before the vector is declared failed.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: start pulse; only sampled in IDLE.
- `num_vec` in ADDR_W-1: number of vectors to run; values above 2^(ADDR_W-2) clamp to 2^(ADDR_W-2).
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: write enable; 0 = read.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid the cycle after a read strobe.
- `add_valid` out 1: operands valid to the adder.
- `add_ready` in 1: adder accepts the operands.
- `add_a`, `add_b` out 32: IEEE-754 single-precision operands.
- `add_res_valid` in 1: adder sum valid (1-cycle pulse).
- `add_res` in 32: adder sum.
- `busy` out 1: high outside IDLE.
- `done` out 1: 1-cycle pulse at the end of a run.
- `match` out 1: result of the most recent compare.
- `timeout_err` out 1: sticky per run; set if any vector timed out.
- `pass_cnt`, `fail_cnt` out 8: saturating at 255.

## Operation
States and transitions:
- **IDLE**: on `start`, clear the counters, `match` and `timeout_err`; set i=0.
  - Clamped `num_vec`=0 goes to DONE.
  - Otherwise go to RD_A.
- **RD_A**: read addr 4i.
- **RD_B**: read addr 4i+1; capture `mem_rdata` into A.
- **RD_E**: read addr 4i+2; capture B.
- **CAP_E**: capture the expected word E; no memory access.
- **ISSUE**: `add_valid`=1 with `add_a`/`add_b` held stable until the cycle where `add_ready`=1, then go to WAIT_RES.
- **WAIT_RES**: wait for `add_res_valid`.
  - On arrival: R=`add_res`; `match`=(R==E) bit-exact (−0 ≠ +0, NaN payloads compared raw); increment `pass_cnt` or `fail_cnt`.
  - After `TIMEOUT` cycles without a result: R=0, `match`=0, `fail_cnt`++, `timeout_err`=1.
  - Either way go to WR.
- **WR**: write R to addr 4i+3. If i+1 equals clamped `num_vec` go to DONE, else i++ and go to RD_A.
- **DONE**: `done`=1 for one cycle, then IDLE.

Boundary rules:
- `add_res_valid` outside WAIT_RES is ignored.
- `start` while busy is ignored.
- `add_ready` while `add_valid`=0 has no effect.
- `rst` mid-run: next edge returns to IDLE, suppresses any pending write and clears all outputs.
- Counters saturate at 255, no wrap.
- The addressing index i uses ADDR_W-2 bits.

## Timing
- Reset values: every output is 0 (`mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `add_valid`, `add_a`, `add_b`, `busy`, `done`, `match`, `timeout_err`, `pass_cnt`, `fail_cnt`).
- All outputs are registered; state changes on the `clk` edge only.
- `mem_en` is asserted exactly in RD_A, RD_B, RD_E and WR. `mem_we`=1 only in WR.
- Per-vector minimum is 7 cycles (RD_A, RD_B, RD_E, CAP_E, ISSUE, WAIT_RES, WR), assuming `add_ready`=1 at ISSUE and the result arriving the cycle after acceptance.
- Run latency from `start` to `done` is 7N+1 cycles at minimum.
- `busy` rises the cycle after `start` is accepted and falls with `done`.
- `match`, `pass_cnt` and `fail_cnt` update in the cycle after the result is captured and are stable during WR.

## Structure
- Shared package `fp_seq_pkg` holds:
  - state enum;
  - word offsets OFF_A=0, OFF_B=1, OFF_E=2, OFF_R=3;
  - FP32_W=32;
  - counter width 8.
- Sub-module `fp_seq_watchdog`: loadable down-counter with an expiry flag, used in WAIT_RES.
- The adder is instantiated outside this block.

## Test plan
- **Single passing vector**: mem[0..2]=0xC1280000 (−10.5), 0x40500000 (3.25), 0xC0E80000 (−7.25); adder model returns 0xC0E80000 → mem[3]=0xC0E80000, `match`=1, `pass_cnt`=1, `done` at cycle 8.
- **Two vectors, one mismatch**: vector 1 is 10.5+3.25 with expected 0x415C0000, adder returns 0x415C0001 → `pass_cnt`=1, `fail_cnt`=1, `match`=0, mem[7]=0x415C0001.
- **Backpressure and timeout**:
  - `add_ready` held low 5 cycles → `add_a`/`add_b` stable throughout.
  - With `TIMEOUT`=4, no result → `timeout_err`=1, `fail_cnt`=1, mem[3]=0.
- **`num_vec`=0** → `done` pulse 1 cycle after `start`, no memory access, counts 0.
- **`rst` during WAIT_RES** → IDLE next cycle, no write to mem[3], all outputs 0; a new `start` runs normally.
- **Stray and ignored inputs**: `add_res_valid` pulse during RD_B is ignored; `start` pulse during a run is ignored; 300 passing vectors (ADDR_W=10) → `pass_cnt` saturates at 255.

Source files
------------

// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP32 adder test-vector sequencer.
package fp_seq_pkg;

    localparam int FP32_W = 32;
    localparam int CNT_W  = 8;

    // Word offsets inside one 4-word vector slot
    localparam logic [1:0] OFF_A = 2'd0;
    localparam logic [1:0] OFF_B = 2'd1;
    localparam logic [1:0] OFF_E = 2'd2;
    localparam logic [1:0] OFF_R = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_RD_E,
        ST_CAP_E,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fp_seq_watchdog.sv
// Loadable down-counter that flags expiry while the sequencer waits for a sum.
module fp_seq_watchdog #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is seen during the last permitted wait cycle
    assign expired = (cnt_q <= W'(1));

endmodule

// File: rtl/fp_add_sequencer.sv
// Fetches A/B/expected from memory, drives the FP32 adder, checks and writes back the sum.
module fp_add_sequencer
    import fp_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-2:0] num_vec,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [FP32_W-1:0] mem_wdata,
    input  logic [FP32_W-1:0] mem_rdata,
    output logic              add_valid,
    input  logic              add_ready,
    output logic [FP32_W-1:0] add_a,
    output logic [FP32_W-1:0] add_b,
    input  logic              add_res_valid,
    input  logic [FP32_W-1:0] add_res,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int NV_W  = ADDR_W - 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [NV_W-1:0] MAX_VEC = {1'b1, {IDX_W{1'b0}}};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NV_W-1:0]    nvec_q, nvec_d, nvec_clamp;
    logic [FP32_W-1:0]  add_a_q, add_a_d, add_b_q, add_b_d, exp_q, exp_d;
    logic [FP32_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic               add_valid_q, add_valid_d, busy_q, busy_d, done_q, done_d;
    logic               match_q, match_d, timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
    logic               wd_load, wd_dec, wd_expired;

    assign nvec_clamp = (num_vec > MAX_VEC) ? MAX_VEC : num_vec;

    fp_seq_watchdog #(.W(WD_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .dec      (wd_dec),
        .load_val (WD_W'(TIMEOUT)),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        nvec_d        = nvec_q;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        exp_d         = exp_q;
        mem_wdata_d   = mem_wdata_q;
        match_d       = match_q;
        timeout_err_d = timeout_err_q;
        pass_cnt_d    = pass_cnt_q;
        fail_cnt_d    = fail_cnt_q;
        wd_load       = 1'b0;
        wd_dec        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d         = '0;
                    nvec_d        = nvec_clamp;
                    match_d       = 1'b0;
                    timeout_err_d = 1'b0;
                    pass_cnt_d    = '0;
                    fail_cnt_d    = '0;
                    state_d       = (nvec_clamp == '0) ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A:  state_d = ST_RD_B;
            ST_RD_B: begin
                add_a_d = mem_rdata;
                state_d = ST_RD_E;
            end
            ST_RD_E: begin
                add_b_d = mem_rdata;
                state_d = ST_CAP_E;
            end
            ST_CAP_E: begin
                exp_d   = mem_rdata;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (add_valid_q && add_ready) begin
                    wd_load = 1'b1;
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                // A result arriving on the expiry cycle still counts as a result
                if (add_res_valid) begin
                    mem_wdata_d = add_res;
                    match_d     = (add_res == exp_q);
                    if (add_res == exp_q) begin
                        pass_cnt_d = sat_inc(pass_cnt_q);
                    end else begin
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end
                    state_d = ST_WR;
                end else if (wd_expired) begin
                    mem_wdata_d   = '0;
                    match_d       = 1'b0;
                    fail_cnt_d    = sat_inc(fail_cnt_q);
                    timeout_err_d = 1'b1;
                    state_d       = ST_WR;
                end else begin
                    wd_dec = 1'b1;
                end
            end
            ST_WR: begin
                if (({1'b0, idx_q} + 1'b1) == nvec_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD_A;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        case (state_d)
            ST_RD_A: begin
                mem_en_d   = 1'b1;
                mem_addr_d = {idx_d, OFF_A};
            end
            ST_RD_B: begin
                mem_en_d   = 1'b1;
                mem_addr_d = {idx_d, OFF_B};
            end
            ST_RD_E: begin
                mem_en_d   = 1'b1;
                mem_addr_d = {idx_d, OFF_E};
            end
            ST_WR: begin
                mem_en_d   = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = {idx_d, OFF_R};
            end
            default: ;
        endcase
        add_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            nvec_q        <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            exp_q         <= '0;
            mem_wdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            add_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            match_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            nvec_q        <= nvec_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            exp_q         <= exp_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            add_valid_q   <= add_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            match_q       <= match_d;
            timeout_err_q <= timeout_err_d;
            pass_cnt_q    <= pass_cnt_d;
            fail_cnt_q    <= fail_cnt_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign add_valid   = add_valid_q;
    assign add_a       = add_a_q;
    assign add_b       = add_b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign timeout_err = timeout_err_q;
    assign pass_cnt    = pass_cnt_q;
    assign fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a word memory and a scripted adder model.
module tb_fp_add_sequencer;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-2:0] num_vec = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          add_valid, add_ready;
    logic [31:0]   add_a, add_b;
    logic          add_res_valid;
    logic [31:0]   add_res;
    logic          busy, done, match, timeout_err;
    logic [7:0]    pass_cnt, fail_cnt;

    // Memory, preload port and adder-model state
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;
    int            acc_cnt = 0;
    logic [31:0]   res_tab [0:255];
    logic          res_en = 1'b1;
    int            ready_delay = 0;
    int            valid_cycles = 0;
    logic [7:0]    vec_ptr = '0;
    logic          mdl_clr = 1'b0;
    logic          mdl_valid = 1'b0;
    logic [31:0]   mdl_res = '0;
    logic          stray_valid = 1'b0;
    logic [31:0]   stray_res = 32'hDEADBEEF;

    int checks = 0;
    int failures = 0;
    int cyc;
    int acc_base;
    int valid_seen;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_a = '0, hold_b = '0;

    fp_add_sequencer #(.ADDR_W(AW), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_vec       (num_vec),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .add_valid     (add_valid),
        .add_ready     (add_ready),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_res_valid (add_res_valid),
        .add_res       (add_res),
        .busy          (busy),
        .done          (done),
        .match         (match),
        .timeout_err   (timeout_err),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Synchronous word memory: read data appears the cycle after the strobe
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr];
        end
        if (mem_en) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    // Adder model: ready after ready_delay valid cycles, sum from res_tab one cycle after acceptance
    always @(posedge clk) begin
        mdl_valid <= 1'b0;
        if (rst || mdl_clr) begin
            vec_ptr      <= '0;
            valid_cycles <= 0;
        end else if (add_valid && add_ready) begin
            mdl_valid    <= res_en;
            mdl_res      <= res_tab[vec_ptr];
            vec_ptr      <= vec_ptr + 1'b1;
            valid_cycles <= 0;
        end else if (add_valid) begin
            valid_cycles <= valid_cycles + 1;
        end
    end

    assign add_ready     = (valid_cycles >= ready_delay);
    assign add_res_valid = mdl_valid | stray_valid;
    assign add_res       = stray_valid ? stray_res : mdl_res;

    // Single comparison point: counts and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Every output must read zero while in or just out of reset
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flags"},
                    {25'd0, mem_en, mem_we, add_valid, busy, done, match, timeout_err}, 32'd0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_add_a"}, add_a, 32'd0);
        checkOutput({tag, "_add_b"}, add_b, 32'd0);
        checkOutput({tag, "_cnts"}, {16'd0, pass_cnt, fail_cnt}, 32'd0);
    endtask

    // Preload one memory word through the bench port
    task automatic memLoad(input int addr, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_addr = AW'(addr);
        pre_data = data;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Pulse start, then count cycles up to done; optional mid-run start and stray result pulses
    task automatic applyStimulus(input int nv, input int start_at, input int stray_at, output int cycles);
        @(negedge clk);
        acc_base = acc_cnt;
        num_vec  = (AW-1)'(nv);
        start    = 1'b1;
        mdl_clr  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        mdl_clr    = 1'b0;
        cycles     = 1;
        valid_seen = 0;
        while (!done && cycles < 3000) begin
            if (hold_chk && add_valid) begin
                checkOutput("add_a_hold", add_a, hold_a);
                checkOutput("add_b_hold", add_b, hold_b);
                valid_seen++;
            end
            start       = (cycles == start_at);
            stray_valid = (cycles == stray_at);
            @(negedge clk);
            cycles++;
        end
        start       = 1'b0;
        stray_valid = 1'b0;
        if (!done) checkOutput("done_wait", 32'(done), 32'd1);
    endtask

    // Directed test sequence
    initial begin
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        memLoad(0, 32'hC1280000);
        memLoad(1, 32'h40500000);
        memLoad(2, 32'hC0E80000);
        memLoad(3, 32'h00000000);
        memLoad(4, 32'h41280000);
        memLoad(5, 32'h40500000);
        memLoad(6, 32'h415C0000);
        res_tab[0] = 32'hC0E80000;
        res_tab[1] = 32'h415C0001;

        $display("[TB] single passing vector");
        applyStimulus(1, -1, -1, cyc);
        checkOutput("t1_latency", 32'(cyc), 32'd8);
        checkOutput("t1_match", 32'(match), 32'd1);
        checkOutput("t1_pass", 32'(pass_cnt), 32'd1);
        checkOutput("t1_fail", 32'(fail_cnt), 32'd0);
        checkOutput("t1_busy_at_done", 32'(busy), 32'd1);
        checkOutput("t1_accesses", 32'(acc_cnt - acc_base), 32'd4);
        checkOutput("t1_mem3", mem[3], 32'hC0E80000);
        @(negedge clk);
        checkOutput("t1_idle", {30'd0, busy, done}, 32'd0);

        $display("[TB] two vectors, one mismatch, stray inputs");
        memLoad(3, 32'h00000000);
        applyStimulus(2, 10, 2, cyc);
        checkOutput("t2_latency", 32'(cyc), 32'd15);
        checkOutput("t2_match", 32'(match), 32'd0);
        checkOutput("t2_pass", 32'(pass_cnt), 32'd1);
        checkOutput("t2_fail", 32'(fail_cnt), 32'd1);
        checkOutput("t2_mem3", mem[3], 32'hC0E80000);
        checkOutput("t2_mem7", mem[7], 32'h415C0001);

        $display("[TB] backpressure");
        ready_delay = 5;
        hold_chk    = 1'b1;
        hold_a      = 32'hC1280000;
        hold_b      = 32'h40500000;
        applyStimulus(1, -1, -1, cyc);
        hold_chk    = 1'b0;
        ready_delay = 0;
        checkOutput("t3_valid_cycles", 32'(valid_seen), 32'd6);
        checkOutput("t3_latency", 32'(cyc), 32'd13);
        checkOutput("t3_pass", 32'(pass_cnt), 32'd1);

        $display("[TB] timeout");
        memLoad(3, 32'hFFFFFFFF);
        res_en = 1'b0;
        applyStimulus(1, -1, -1, cyc);
        res_en = 1'b1;
        checkOutput("t4_latency", 32'(cyc), 32'd11);
        checkOutput("t4_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t4_fail", 32'(fail_cnt), 32'd1);
        checkOutput("t4_pass", 32'(pass_cnt), 32'd0);
        checkOutput("t4_match", 32'(match), 32'd0);
        checkOutput("t4_mem3", mem[3], 32'h00000000);

        $display("[TB] zero vectors");
        applyStimulus(0, -1, -1, cyc);
        checkOutput("t5_latency", 32'(cyc), 32'd1);
        checkOutput("t5_accesses", 32'(acc_cnt - acc_base), 32'd0);
        checkOutput("t5_cnts", {16'd0, pass_cnt, fail_cnt}, 32'd0);
        checkOutput("t5_timeout_err", 32'(timeout_err), 32'd0);

        $display("[TB] reset during WAIT_RES");
        memLoad(3, 32'h12345678);
        res_en  = 1'b0;
        num_vec = (AW-1)'(1);
        start   = 1'b1;
        mdl_clr = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        mdl_clr = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t6_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("t6_after_rst");
        repeat (10) @(negedge clk);
        checkOutput("t6_mem3_kept", mem[3], 32'h12345678);
        checkOutput("t6_still_idle", 32'(busy), 32'd0);
        res_en = 1'b1;
        applyStimulus(1, -1, -1, cyc);
        checkOutput("t6_rerun_latency", 32'(cyc), 32'd8);
        checkOutput("t6_rerun_mem3", mem[3], 32'hC0E80000);
        checkOutput("t6_rerun_pass", 32'(pass_cnt), 32'd1);

        $display("[TB] clamped run, pass counter saturation");
        for (int i = 0; i < 256; i++) begin
            memLoad(4*i, 32'(i));
            memLoad(4*i + 1, 32'd0);
            memLoad(4*i + 2, 32'h3F800000 + 32'(i));
            memLoad(4*i + 3, 32'd0);
            res_tab[i] = 32'h3F800000 + 32'(i);
        end
        applyStimulus(300, -1, -1, cyc);
        checkOutput("t7_latency", 32'(cyc), 32'd1793);
        checkOutput("t7_pass_sat", 32'(pass_cnt), 32'd255);
        checkOutput("t7_fail", 32'(fail_cnt), 32'd0);
        checkOutput("t7_mem_last", mem[1023], 32'h3F8000FF);
        checkOutput("t7_mem_mid", mem[403], 32'h3F800064);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
